// File: rtl/ahb3lite_slave_arbiter.sv
// ---------------------------------------------------------------------------
// ahb3lite_slave_arbiter
//
// Per-slave-port arbiter. Chooses which master owns the address phase of one
// slave port and remembers which master owns the following data phase so the
// interconnect can route HRDATA/HREADY/HRESP back to it.
//
// Winner selection is highest mst_priority among valid (requesting, NONSEQ)
// masters, with round-robin among equal priorities starting after the last
// granted master. Fixed-length bursts and locked sequences are never broken.
//
// Ports:
//   HCLK           clock, rising edge
//   HRESET         synchronous active-high reset
//   mst_req        per-master request (decoded HSEL for this slave)
//   mst_priority   per-master priority, larger value wins
//   mst_HTRANS     per-master HTRANS
//   mst_HBURST     per-master HBURST
//   mst_HMASTLOCK  per-master lock indicator
//   HREADY         slave-port HREADYOUT
//   grant          one-hot address-phase owner, all-zero when nobody owns
//   grant_id       index of address-phase owner, holds when grant is zero
//   data_owner     index of the master in the data phase
//   data_valid     data phase belongs to a real NONSEQ/SEQ transfer
// ---------------------------------------------------------------------------
module ahb3lite_slave_arbiter #(
    parameter int MASTERS     = 3,
    parameter int MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   mst_req       [MASTERS],
    input  logic [MASTER_BITS-1:0] mst_priority  [MASTERS],
    input  logic [1:0]             mst_HTRANS    [MASTERS],
    input  logic [2:0]             mst_HBURST    [MASTERS],
    input  logic                   mst_HMASTLOCK [MASTERS],
    input  logic                   HREADY,
    output logic [MASTERS-1:0]     grant,
    output logic [MASTER_BITS-1:0] grant_id,
    output logic [MASTER_BITS-1:0] data_owner,
    output logic                   data_valid
);

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BURST = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    // Number of SEQ beats that follow the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] burst_seq_beats(input logic [2:0] hburst);
        logic [3:0] beats;
        case (hburst)
            3'd2, 3'd3: beats = 4'd3;   // WRAP4 / INCR4
            3'd4, 3'd5: beats = 4'd7;   // WRAP8 / INCR8
            3'd6, 3'd7: beats = 4'd15;  // WRAP16 / INCR16
            default:    beats = 4'd0;   // SINGLE / INCR
        endcase
        return beats;
    endfunction

    state_t                 state_r;
    logic [MASTERS-1:0]     grant_r;
    logic [MASTER_BITS-1:0] grant_id_r;
    logic [MASTER_BITS-1:0] last_id_r;
    logic [3:0]             beat_cnt_r;
    logic                   first_beat_r;
    logic [MASTER_BITS-1:0] data_owner_r;
    logic                   data_valid_r;

    logic [MASTERS-1:0]     valid_s;
    logic [1:0]             own_trans_s;
    logic                   own_req_s;
    logic                   own_lock_s;
    logic                   arb_point_s;
    logic                   win_found_s;
    logic [MASTER_BITS-1:0] win_id_s;
    logic [MASTER_BITS-1:0] win_prio_s;
    logic [MASTERS-1:0]     win_onehot_s;
    logic [MASTER_BITS-1:0] rr_idx_s;

    assign grant      = grant_r;
    assign grant_id   = grant_id_r;
    assign data_owner = data_owner_r;
    assign data_valid = data_valid_r;

    // Valid requesters: addressing this slave with a NONSEQ transfer.
    always_comb begin
        valid_s = '0;
        for (int i = 0; i < MASTERS; i++) begin
            valid_s[i] = mst_req[i] && (mst_HTRANS[i] == HTRANS_NONSEQ);
        end
    end

    // Current owner's bus signals, indexed by the registered grant id.
    always_comb begin
        own_trans_s = mst_HTRANS[grant_id_r];
        own_req_s   = mst_req[grant_id_r];
        own_lock_s  = mst_HMASTLOCK[grant_id_r];
    end

    // Priority winner; walking in round-robin order from last_id+1 with a
    // strict greater-than keeps the first tied master met in that order.
    always_comb begin
        win_found_s  = 1'b0;
        win_id_s     = '0;
        win_prio_s   = '0;
        win_onehot_s = '0;
        rr_idx_s     = (last_id_r == MASTER_BITS'(MASTERS - 1)) ? '0 : last_id_r + 1'b1;
        for (int k = 0; k < MASTERS; k++) begin
            if (valid_s[rr_idx_s] && (!win_found_s || (mst_priority[rr_idx_s] > win_prio_s))) begin
                win_found_s            = 1'b1;
                win_id_s               = rr_idx_s;
                win_prio_s             = mst_priority[rr_idx_s];
                win_onehot_s           = '0;
                win_onehot_s[rr_idx_s] = 1'b1;
            end else begin
                // keep the current candidate
            end
            rr_idx_s = (rr_idx_s == MASTER_BITS'(MASTERS - 1)) ? '0 : rr_idx_s + 1'b1;
        end
    end

    // Arbitration point decode (qualified by HREADY in the state register).
    // In BURST the NONSEQ that opens the burst is flagged by first_beat_r so
    // it is not mistaken for an early termination.
    always_comb begin
        arb_point_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                arb_point_s = 1'b1;
            end
            ST_OWN: begin
                arb_point_s = !own_req_s ||
                              !((own_trans_s == HTRANS_SEQ) || (own_trans_s == HTRANS_BUSY));
            end
            ST_BURST: begin
                if (!own_req_s) begin
                    arb_point_s = 1'b1;
                end else if (first_beat_r) begin
                    arb_point_s = (own_trans_s == HTRANS_IDLE);
                end else if ((own_trans_s == HTRANS_IDLE) || (own_trans_s == HTRANS_NONSEQ)) begin
                    arb_point_s = 1'b1;
                end else begin
                    // last SEQ beat completes when the count is about to reach zero
                    arb_point_s = (own_trans_s == HTRANS_SEQ) && (beat_cnt_r <= 4'd1);
                end
            end
            ST_LOCK: begin
                arb_point_s = !own_req_s || !own_lock_s;
            end
            default: begin
                arb_point_s = 1'b1;
            end
        endcase
    end

    // Arbitration state machine: state, grant, grant id, round-robin pointer
    // and burst beat counter. Wait states freeze everything.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            grant_id_r   <= '0;
            last_id_r    <= MASTER_BITS'(MASTERS - 1);
            beat_cnt_r   <= 4'd0;
            first_beat_r <= 1'b0;
        end else if (HREADY) begin
            if (arb_point_s) begin
                if (win_found_s) begin
                    grant_r    <= win_onehot_s;
                    grant_id_r <= win_id_s;
                    last_id_r  <= win_id_s;
                    if (mst_HMASTLOCK[win_id_s]) begin
                        state_r      <= ST_LOCK;
                        beat_cnt_r   <= 4'd0;
                        first_beat_r <= 1'b0;
                    end else if (burst_seq_beats(mst_HBURST[win_id_s]) != 4'd0) begin
                        state_r      <= ST_BURST;
                        beat_cnt_r   <= burst_seq_beats(mst_HBURST[win_id_s]);
                        first_beat_r <= 1'b1;
                    end else begin
                        state_r      <= ST_OWN;
                        beat_cnt_r   <= 4'd0;
                        first_beat_r <= 1'b0;
                    end
                end else begin
                    // nobody left: release the port, grant_id keeps its value
                    state_r      <= ST_IDLE;
                    grant_r      <= '0;
                    beat_cnt_r   <= 4'd0;
                    first_beat_r <= 1'b0;
                end
            end else if (state_r == ST_BURST) begin
                if (first_beat_r) begin
                    if (own_trans_s == HTRANS_NONSEQ) begin
                        first_beat_r <= 1'b0;
                    end else begin
                        first_beat_r <= first_beat_r;
                    end
                end else if (own_trans_s == HTRANS_SEQ) begin
                    beat_cnt_r <= beat_cnt_r - 4'd1;
                end else begin
                    beat_cnt_r <= beat_cnt_r;  // BUSY does not consume a beat
                end
            end else begin
                state_r <= state_r;
            end
        end else begin
            state_r <= state_r;
        end
    end

    // Data-phase tracking: the address phase owned on this edge becomes the
    // data phase from the next one.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_owner_r <= '0;
            data_valid_r <= 1'b0;
        end else if (HREADY) begin
            data_owner_r <= grant_id_r;
            data_valid_r <= (|grant_r) &&
                            ((own_trans_s == HTRANS_NONSEQ) || (own_trans_s == HTRANS_SEQ));
        end else begin
            data_owner_r <= data_owner_r;
            data_valid_r <= data_valid_r;
        end
    end

endmodule

// File: tb/tb_ahb3lite_slave_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for ahb3lite_slave_arbiter (MASTERS = 3). Each step pushes
// the expected outputs after the coming clock edge into a scoreboard queue,
// then pops and compares once the edge has happened.
// ---------------------------------------------------------------------------
module tb_ahb3lite_slave_arbiter;

    localparam int MASTERS = 3;
    localparam int MB      = 2;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_WRAP8  = 3'd4;
    localparam logic [2:0] B_INCR16 = 3'd7;

    typedef struct packed {
        logic [MASTERS-1:0] grant;
        logic [MB-1:0]      gid;
        logic [MB-1:0]      dow;
        logic               dv;
    } exp_t;

    logic          hclk;
    logic          hreset;
    logic          hready;
    logic          req    [MASTERS];
    logic [MB-1:0] prio   [MASTERS];
    logic [1:0]    htrans [MASTERS];
    logic [2:0]    hburst [MASTERS];
    logic          lock   [MASTERS];

    logic [MASTERS-1:0] grant;
    logic [MB-1:0]      grant_id;
    logic [MB-1:0]      data_owner;
    logic               data_valid;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    ahb3lite_slave_arbiter #(.MASTERS(MASTERS)) dut (
        .HCLK          (hclk),
        .HRESET        (hreset),
        .mst_req       (req),
        .mst_priority  (prio),
        .mst_HTRANS    (htrans),
        .mst_HBURST    (hburst),
        .mst_HMASTLOCK (lock),
        .HREADY        (hready),
        .grant         (grant),
        .grant_id      (grant_id),
        .data_owner    (data_owner),
        .data_valid    (data_valid)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic set_m(input int i, input logic r, input logic [1:0] t,
                         input logic [2:0] b, input logic l, input logic [MB-1:0] p);
        req[i]    = r;
        htrans[i] = t;
        hburst[i] = b;
        lock[i]   = l;
        prio[i]   = p;
    endtask

    task automatic check_front();
        exp_t  e;
        string tag;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: got 0 entries, expected at least 1");
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            assert (grant === e.grant) else begin
                errors++;
                $error("FAIL %s grant: got %b expected %b", tag, grant, e.grant);
            end
            checks++;
            assert (grant_id === e.gid) else begin
                errors++;
                $error("FAIL %s grant_id: got %0d expected %0d", tag, grant_id, e.gid);
            end
            checks++;
            assert (data_owner === e.dow) else begin
                errors++;
                $error("FAIL %s data_owner: got %0d expected %0d", tag, data_owner, e.dow);
            end
            checks++;
            assert (data_valid === e.dv) else begin
                errors++;
                $error("FAIL %s data_valid: got %b expected %b", tag, data_valid, e.dv);
            end
        end
    endtask

    // Push what the outputs must be after the next rising edge, then check.
    task automatic step(input logic [MASTERS-1:0] g, input logic [MB-1:0] gid,
                        input logic [MB-1:0] dow, input logic dv, input string tag);
        exp_t e;
        e.grant = g;
        e.gid   = gid;
        e.dow   = dow;
        e.dv    = dv;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge hclk);
        #1;
        check_front();
    endtask

    initial begin
        hreset = 1'b1;
        hready = 1'b1;
        for (int i = 0; i < MASTERS; i++) set_m(i, 1'b0, T_IDLE, B_SINGLE, 1'b0, 2'd0);
        step(3'b000, 2'd0, 2'd0, 1'b0, "reset_a");
        step(3'b000, 2'd0, 2'd0, 1'b0, "reset_b");
        hreset = 1'b0;

        // Equal priorities: plain round-robin starting at master 0
        for (int i = 0; i < MASTERS; i++) set_m(i, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 2'd0);
        step(3'b001, 2'd0, 2'd0, 1'b0, "rr_first");
        step(3'b010, 2'd1, 2'd0, 1'b1, "rr_m1");
        step(3'b100, 2'd2, 2'd1, 1'b1, "rr_m2");
        step(3'b001, 2'd0, 2'd2, 1'b1, "rr_wrap");

        // Priorities {0,2,1}: master 1 dominates until it drops out
        prio[0] = 2'd0;
        prio[1] = 2'd2;
        prio[2] = 2'd1;
        step(3'b010, 2'd1, 2'd0, 1'b1, "prio_m1_a");
        step(3'b010, 2'd1, 2'd1, 1'b1, "prio_m1_b");
        step(3'b010, 2'd1, 2'd1, 1'b1, "prio_m1_c");
        set_m(1, 1'b0, T_IDLE, B_SINGLE, 1'b0, 2'd2);
        step(3'b100, 2'd2, 2'd1, 1'b0, "prio_drop");
        step(3'b100, 2'd2, 2'd2, 1'b1, "prio_m2");

        // Everyone leaves: port idles, grant_id keeps the last owner
        for (int i = 0; i < MASTERS; i++) set_m(i, 1'b0, T_IDLE, B_SINGLE, 1'b0, 2'd0);
        step(3'b000, 2'd2, 2'd2, 1'b0, "idle_hold_id");

        // INCR4 on master 0, higher-priority master 2 arrives at beat 2
        set_m(0, 1'b1, T_NONSEQ, B_INCR4, 1'b0, 2'd0);
        step(3'b001, 2'd0, 2'd2, 1'b0, "b4_grant");
        step(3'b001, 2'd0, 2'd0, 1'b1, "b4_beat1");
        htrans[0] = T_SEQ;
        set_m(2, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 2'd2);
        step(3'b001, 2'd0, 2'd0, 1'b1, "b4_beat2");
        hready = 1'b0;
        step(3'b001, 2'd0, 2'd0, 1'b1, "b4_wait1");
        step(3'b001, 2'd0, 2'd0, 1'b1, "b4_wait2");
        hready = 1'b1;
        step(3'b001, 2'd0, 2'd0, 1'b1, "b4_beat3");
        step(3'b100, 2'd2, 2'd0, 1'b1, "b4_handover");

        // Master 1 locked over six singles, others keep requesting
        set_m(0, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 2'd0);
        set_m(1, 1'b1, T_NONSEQ, B_SINGLE, 1'b1, 2'd2);
        set_m(2, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 2'd0);
        step(3'b010, 2'd1, 2'd2, 1'b1, "lock_grant");
        prio[1] = 2'd0;
        for (int n = 0; n < 6; n++) step(3'b010, 2'd1, 2'd1, 1'b1, "lock_hold");
        lock[1] = 1'b0;
        step(3'b100, 2'd2, 2'd1, 1'b1, "lock_release");

        // WRAP8 on master 0 cut short by a NONSEQ after beat 3
        set_m(0, 1'b1, T_NONSEQ, B_WRAP8, 1'b0, 2'd0);
        set_m(1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 2'd0);
        set_m(2, 1'b0, T_IDLE, B_SINGLE, 1'b0, 2'd0);
        step(3'b001, 2'd0, 2'd2, 1'b0, "w8_grant");
        step(3'b001, 2'd0, 2'd0, 1'b1, "w8_beat1");
        htrans[0] = T_SEQ;
        step(3'b001, 2'd0, 2'd0, 1'b1, "w8_beat2");
        step(3'b001, 2'd0, 2'd0, 1'b1, "w8_beat3");
        htrans[0] = T_NONSEQ;
        hburst[0] = B_SINGLE;
        step(3'b010, 2'd1, 2'd0, 1'b1, "w8_early_end");

        // INCR16 on master 0, reset during beat 5
        set_m(1, 1'b0, T_IDLE, B_SINGLE, 1'b0, 2'd0);
        set_m(0, 1'b1, T_NONSEQ, B_INCR16, 1'b0, 2'd0);
        step(3'b001, 2'd0, 2'd1, 1'b0, "i16_grant");
        step(3'b001, 2'd0, 2'd0, 1'b1, "i16_beat1");
        htrans[0] = T_SEQ;
        step(3'b001, 2'd0, 2'd0, 1'b1, "i16_beat2");
        step(3'b001, 2'd0, 2'd0, 1'b1, "i16_beat3");
        step(3'b001, 2'd0, 2'd0, 1'b1, "i16_beat4");
        hreset = 1'b1;
        step(3'b000, 2'd0, 2'd0, 1'b0, "i16_reset");
        hreset = 1'b0;
        for (int i = 0; i < MASTERS; i++) set_m(i, 1'b1, T_NONSEQ, B_SINGLE, 1'b0, 2'd0);
        step(3'b001, 2'd0, 2'd0, 1'b0, "post_reset_tie");
        step(3'b010, 2'd1, 2'd0, 1'b1, "post_reset_rr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
